// File: rtl/bus_transfer_controller.sv
// Initiator for the shared bidirectional register bus: sequences DRIVE/LATCH/RELEASE strobes per transfer.
// Optional bus snooping is enabled by defining BUS_SNOOP_EN.
module bus_transfer_controller #(
    parameter int BUS_WIDTH = 16,
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [SEL_WIDTH-1:0] i_req_src,
    input  logic [SEL_WIDTH-1:0] i_req_dst,
    input  logic                 i_req_inc,
    output logic                 o_done,
    output logic                 o_error,
    output logic [NUM_REGS-1:0]  o_reg_enable,
    output logic [NUM_REGS-1:0]  o_reg_rw,
    output logic [NUM_REGS-1:0]  o_reg_count,
    input  logic [BUS_WIDTH-1:0] i_bus_data,
    output logic [BUS_WIDTH-1:0] o_snoop_data,
    output logic                 o_snoop_vld
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LATCH,
        RELEASE,
        FAULT
    } state_t;

    state_t r_state, w_nextState;

    logic [SEL_WIDTH-1:0] r_src, r_dst;
    logic                 r_inc;
    logic                 r_reqReady, r_done, r_error;
    logic [NUM_REGS-1:0]  r_regEnable, r_regRw, r_regCount;

    logic                 w_accept, w_bad, w_inc;
    logic [SEL_WIDTH-1:0] w_src, w_dst;
    logic [NUM_REGS-1:0]  w_srcOneHot, w_dstOneHot;
    logic                 w_reqReady, w_done, w_error;
    logic [NUM_REGS-1:0]  w_regEnable, w_regRw, w_regCount;

    assign w_accept = i_req_valid && r_reqReady;

    // Outputs are registered, so strobes are derived from the state being entered.
    always_comb begin
        w_src       = w_accept ? i_req_src : r_src;
        w_dst       = w_accept ? i_req_dst : r_dst;
        w_inc       = w_accept ? i_req_inc : r_inc;
        w_srcOneHot = NUM_REGS'(1) << w_src;
        w_dstOneHot = NUM_REGS'(1) << w_dst;
        w_bad       = (w_src == w_dst) || (32'(w_src) >= NUM_REGS) || (32'(w_dst) >= NUM_REGS);

        w_nextState = IDLE;
        case (r_state)
            IDLE:    w_nextState = w_accept ? (w_bad ? FAULT : DRIVE) : IDLE;
            DRIVE:   w_nextState = LATCH;
            LATCH:   w_nextState = RELEASE;
            RELEASE: w_nextState = IDLE;
            FAULT:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase

        w_regEnable = '0;
        w_regRw     = '1;
        w_regCount  = '0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_reqReady  = (w_nextState == IDLE);
        case (w_nextState)
            DRIVE: w_regEnable = w_srcOneHot;
            LATCH: begin
                w_regEnable = w_srcOneHot | w_dstOneHot;
                w_regRw     = ~w_dstOneHot;
            end
            RELEASE: begin
                w_regCount = w_inc ? w_srcOneHot : '0;
                w_done     = 1'b1;
            end
            FAULT: begin
                w_done  = 1'b1;
                w_error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_inc       <= 1'b0;
            r_reqReady  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_regEnable <= '0;
            r_regRw     <= '1;
            r_regCount  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_src <= i_req_src;
                r_dst <= i_req_dst;
                r_inc <= i_req_inc;
            end
            r_reqReady  <= w_reqReady;
            r_done      <= w_done;
            r_error     <= w_error;
            r_regEnable <= w_regEnable;
            r_regRw     <= w_regRw;
            r_regCount  <= w_regCount;
        end
    end

    assign o_req_ready  = r_reqReady;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_reg_enable = r_regEnable;
    assign o_reg_rw     = r_regRw;
    assign o_reg_count  = r_regCount;

`ifdef BUS_SNOOP_EN
    logic [BUS_WIDTH-1:0] r_snoopData;
    logic                 r_snoopVld;

    // The word on the bus at the end of LATCH is what the destination captured.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_snoopData <= '0;
            r_snoopVld  <= 1'b0;
        end else begin
            if (r_state == LATCH) begin
                r_snoopData <= i_bus_data;
            end
            r_snoopVld <= (r_state == LATCH);
        end
    end

    assign o_snoop_data = r_snoopData;
    assign o_snoop_vld  = r_snoopVld;
`else
    logic w_unusedBus;
    assign w_unusedBus  = ^i_bus_data;
    assign o_snoop_data = '0;
    assign o_snoop_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed testbench for bus_transfer_controller: table of transfers plus reset and back-to-back sequences.
module tb_bus_transfer_controller;

    localparam int BUS_WIDTH = 16;
    localparam int NUM_REGS  = 8;
    localparam int SEL_WIDTH = 4;

`ifdef BUS_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 reqValid;
    logic                 reqReady;
    logic [SEL_WIDTH-1:0] reqSrc, reqDst;
    logic                 reqInc;
    logic                 done, error;
    logic [NUM_REGS-1:0]  regEnable, regRw, regCount;
    logic [BUS_WIDTH-1:0] busData, snoopData;
    logic                 snoopVld;

    int nChecks = 0;
    int nPassed = 0;

    always #5 clock = ~clock;

    bus_transfer_controller #(
        .BUS_WIDTH(BUS_WIDTH),
        .NUM_REGS (NUM_REGS),
        .SEL_WIDTH(SEL_WIDTH)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_src   (reqSrc),
        .i_req_dst   (reqDst),
        .i_req_inc   (reqInc),
        .o_done      (done),
        .o_error     (error),
        .o_reg_enable(regEnable),
        .o_reg_rw    (regRw),
        .o_reg_count (regCount),
        .i_bus_data  (busData),
        .o_snoop_data(snoopData),
        .o_snoop_vld (snoopVld)
    );

    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
        logic       inc;
        logic       fault;
        logic [7:0] en1;
        logic [7:0] en2;
        logic [7:0] rw2;
        logic [7:0] cnt3;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPassed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One request pulse, then cycle-by-cycle checks of the strobe sequence.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        reqSrc   = v.src;
        reqDst   = v.dst;
        reqInc   = v.inc;
        reqValid = 1'b1;
        busData  = 16'h1234;
        checkOutput("ready_c0", 32'(reqReady), 32'd1);
        @(negedge clock);
        reqValid = 1'b0;
        if (v.fault) begin
            checkOutput("fault_done_c1", 32'(done), 32'd1);
            checkOutput("fault_error_c1", 32'(error), 32'd1);
            checkOutput("fault_en_c1", 32'(regEnable), 32'h00);
            checkOutput("fault_count_c1", 32'(regCount), 32'h00);
            checkOutput("fault_ready_c1", 32'(reqReady), 32'd0);
            checkOutput("fault_snoopvld_c1", 32'(snoopVld), 32'd0);
            @(negedge clock);
            checkOutput("fault_done_c2", 32'(done), 32'd0);
            checkOutput("fault_ready_c2", 32'(reqReady), 32'd1);
        end else begin
            checkOutput("en_c1", 32'(regEnable), 32'(v.en1));
            checkOutput("rw_c1", 32'(regRw), 32'hFF);
            checkOutput("done_c1", 32'(done), 32'd0);
            checkOutput("ready_c1", 32'(reqReady), 32'd0);
            busData = 16'hBEEF;
            @(negedge clock);
            checkOutput("en_c2", 32'(regEnable), 32'(v.en2));
            checkOutput("rw_c2", 32'(regRw), 32'(v.rw2));
            checkOutput("done_c2", 32'(done), 32'd0);
            checkOutput("ready_c2", 32'(reqReady), 32'd0);
            @(negedge clock);
            busData = 16'h5555;
            checkOutput("en_c3", 32'(regEnable), 32'h00);
            checkOutput("rw_c3", 32'(regRw), 32'hFF);
            checkOutput("count_c3", 32'(regCount), 32'(v.cnt3));
            checkOutput("done_c3", 32'(done), 32'd1);
            checkOutput("error_c3", 32'(error), 32'd0);
            checkOutput("ready_c3", 32'(reqReady), 32'd0);
            checkOutput("snoopvld_c3", 32'(snoopVld), 32'(SNOOP));
            checkOutput("snoopdata_c3", 32'(snoopData), SNOOP ? 32'hBEEF : 32'h0);
            @(negedge clock);
            checkOutput("ready_c4", 32'(reqReady), 32'd1);
            checkOutput("done_c4", 32'(done), 32'd0);
            checkOutput("count_c4", 32'(regCount), 32'h00);
        end
    endtask

    initial begin
        vecs[0] = '{src: 4'd1, dst: 4'd4, inc: 1'b0, fault: 1'b0, en1: 8'h02, en2: 8'h12, rw2: 8'hEF, cnt3: 8'h00};
        vecs[1] = '{src: 4'd2, dst: 4'd0, inc: 1'b1, fault: 1'b0, en1: 8'h04, en2: 8'h05, rw2: 8'hFE, cnt3: 8'h04};
        vecs[2] = '{src: 4'd7, dst: 4'd6, inc: 1'b1, fault: 1'b0, en1: 8'h80, en2: 8'hC0, rw2: 8'hBF, cnt3: 8'h80};
        vecs[3] = '{src: 4'd0, dst: 4'd7, inc: 1'b0, fault: 1'b0, en1: 8'h01, en2: 8'h81, rw2: 8'h7F, cnt3: 8'h00};
        vecs[4] = '{src: 4'd3, dst: 4'd3, inc: 1'b1, fault: 1'b1, en1: 8'h00, en2: 8'h00, rw2: 8'hFF, cnt3: 8'h00};
        vecs[5] = '{src: 4'd9, dst: 4'd2, inc: 1'b1, fault: 1'b1, en1: 8'h00, en2: 8'h00, rw2: 8'hFF, cnt3: 8'h00};
        vecs[6] = '{src: 4'd2, dst: 4'd8, inc: 1'b0, fault: 1'b1, en1: 8'h00, en2: 8'h00, rw2: 8'hFF, cnt3: 8'h00};

        reset    = 1'b1;
        reqValid = 1'b0;
        reqSrc   = '0;
        reqDst   = '0;
        reqInc   = 1'b0;
        busData  = '0;
        repeat (2) @(negedge clock);
        checkOutput("rst_ready", 32'(reqReady), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_en", 32'(regEnable), 32'h00);
        checkOutput("rst_rw", 32'(regRw), 32'hFF);
        checkOutput("rst_count", 32'(regCount), 32'h00);
        checkOutput("rst_snoopdata", 32'(snoopData), 32'h0);
        checkOutput("rst_snoopvld", 32'(snoopVld), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Held REQ_VALID: second request is accepted in c4, DONE at c3 and c7.
        @(negedge clock);
        reqSrc   = 4'd1;
        reqDst   = 4'd2;
        reqInc   = 1'b0;
        reqValid = 1'b1;
        checkOutput("b2b_ready_c0", 32'(reqReady), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 5) reqValid = 1'b0;
            checkOutput($sformatf("b2b_done_c%0d", c), 32'(done), 32'((c == 3) || (c == 7)));
            checkOutput($sformatf("b2b_ready_c%0d", c), 32'(reqReady), 32'((c == 4) || (c == 8)));
            if (c == 5) checkOutput("b2b_en_c5", 32'(regEnable), 32'h02);
        end

        // Reset during LATCH aborts the transfer without a DONE.
        @(negedge clock);
        reqSrc   = 4'd5;
        reqDst   = 4'd6;
        reqValid = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        checkOutput("abort_en_latch", 32'(regEnable), 32'h60);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_en", 32'(regEnable), 32'h00);
        checkOutput("abort_rw", 32'(regRw), 32'hFF);
        checkOutput("abort_ready", 32'(reqReady), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("abort_nodone_%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("abort_idle_en_%0d", c), 32'(regEnable), 32'h00);
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
